mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and payload signals between EXE, MEM, WB and the ID bypass path.
interface mem_stage_if #(
  parameter int unsigned EXE_MEM_WD = 74,
  parameter int unsigned MEM_WB_WD  = 70
);
  localparam int unsigned FWD_WD  = 38;
  localparam int unsigned WORD_WD = 32;

  logic                  exe_to_mem_valid;
  logic [EXE_MEM_WD-1:0] exe_to_mem_bus;
  logic                  mem_allowin;
  logic [WORD_WD-1:0]    data_sram_rdata;
  logic                  wb_allowin;
  logic                  mem_to_wb_valid;
  logic [MEM_WB_WD-1:0]  mem_to_wb_bus;
  logic [FWD_WD-1:0]     mem_fwd_bus;

  // Pipeline-stage side.
  modport slave (
    input  exe_to_mem_valid,
    input  exe_to_mem_bus,
    input  data_sram_rdata,
    input  wb_allowin,
    output mem_allowin,
    output mem_to_wb_valid,
    output mem_to_wb_bus,
    output mem_fwd_bus
  );

  // Neighbouring-stage / environment side.
  modport master (
    output exe_to_mem_valid,
    output exe_to_mem_bus,
    output data_sram_rdata,
    output wb_allowin,
    input  mem_allowin,
    input  mem_to_wb_valid,
    input  mem_to_wb_bus,
    input  mem_fwd_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, selects/extends load data, feeds WB and the ID bypass.
module mem_stage #(
  parameter int unsigned EXE_MEM_WD = 74,
  parameter int unsigned MEM_WB_WD  = 70
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  mem_if
);
  localparam int unsigned WORD_WD = 32;
  localparam int unsigned HALF_WD = 16;
  localparam int unsigned BYTE_WD = 8;
  localparam int unsigned FWD_WD  = 38;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef struct packed {
    logic               res_from_mem;
    logic [2:0]         ld_type;
    logic               gr_we;
    logic [4:0]         dest;
    logic [WORD_WD-1:0] alu_result;
    logic [WORD_WD-1:0] pc;
  } exe_mem_t;

  typedef struct packed {
    logic               gr_we;
    logic [4:0]         dest;
    logic [WORD_WD-1:0] final_result;
    logic [WORD_WD-1:0] pc;
  } mem_wb_t;

  typedef struct packed {
    logic               we;
    logic [4:0]         dest;
    logic [WORD_WD-1:0] result;
  } fwd_t;

  logic                  mem_valid_q, mem_valid_d;
  logic                  fresh_q, fresh_d;
  logic [EXE_MEM_WD-1:0] bus_q, bus_d;
  logic [WORD_WD-1:0]    rdata_q, rdata_d;

  logic               mem_valid_c;
  logic               mem_allowin_c;
  logic               accept_c;
  exe_mem_t           ex_c;
  logic [WORD_WD-1:0] rdata_c;
  logic [BYTE_WD-1:0] byte_c;
  logic [HALF_WD-1:0] half_c;
  logic [WORD_WD-1:0] load_c;
  logic [WORD_WD-1:0] final_c;
  mem_wb_t            wb_c;
  fwd_t               fwd_c;

  // Reset masks the stage immediately so nothing leaks to WB or the bypass.
  assign mem_valid_c   = mem_valid_q & ~reset;
  assign mem_allowin_c = ~mem_valid_c | mem_if.wb_allowin;
  assign accept_c      = mem_if.exe_to_mem_valid & mem_allowin_c;

  // Next-state: valid follows EXE when allowed; payload and fresh flag only on accept.
  always_comb begin
    mem_valid_d = mem_valid_q;
    fresh_d     = 1'b0;
    bus_d       = bus_q;
    rdata_d     = rdata_q;
    if (mem_allowin_c) begin
      mem_valid_d = mem_if.exe_to_mem_valid;
    end
    if (accept_c) begin
      bus_d   = mem_if.exe_to_mem_bus;
      fresh_d = 1'b1;
    end
    if (fresh_q) begin
      rdata_d = mem_if.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      fresh_q     <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      fresh_q     <= fresh_d;
    end
  end

  // Payload and read-data buffer are don't-care while invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    bus_q   <= bus_d;
    rdata_q <= rdata_d;
  end

  assign ex_c = bus_q;

  // SRAM data is only valid in the first cycle after acceptance; later cycles use the buffer.
  assign rdata_c = fresh_q ? mem_if.data_sram_rdata : rdata_q;

  always_comb begin
    byte_c = rdata_c[7:0];
    unique case (ex_c.alu_result[1:0])
      2'b00: byte_c = rdata_c[7:0];
      2'b01: byte_c = rdata_c[15:8];
      2'b10: byte_c = rdata_c[23:16];
      2'b11: byte_c = rdata_c[31:24];
      default: byte_c = rdata_c[7:0];
    endcase
  end

  // Halfword select deliberately ignores address bit 0; misalignment is not trapped.
  assign half_c = ex_c.alu_result[1] ? rdata_c[31:16] : rdata_c[15:0];

  always_comb begin
    load_c = rdata_c;
    case (ex_c.ld_type)
      LD_LB:   load_c = {{(WORD_WD-BYTE_WD){byte_c[BYTE_WD-1]}}, byte_c};
      LD_LBU:  load_c = {{(WORD_WD-BYTE_WD){1'b0}}, byte_c};
      LD_LH:   load_c = {{(WORD_WD-HALF_WD){half_c[HALF_WD-1]}}, half_c};
      LD_LHU:  load_c = {{(WORD_WD-HALF_WD){1'b0}}, half_c};
      default: load_c = rdata_c;
    endcase
  end

  assign final_c = ex_c.res_from_mem ? load_c : ex_c.alu_result;

  always_comb begin
    wb_c.gr_we        = ex_c.gr_we;
    wb_c.dest         = ex_c.dest;
    wb_c.final_result = final_c;
    wb_c.pc           = ex_c.pc;
    fwd_c.we          = mem_valid_c & ex_c.gr_we;
    fwd_c.dest        = ex_c.dest;
    fwd_c.result      = final_c;
  end

  assign mem_if.mem_allowin     = mem_allowin_c;
  assign mem_if.mem_to_wb_valid = mem_valid_c;
  assign mem_if.mem_to_wb_bus   = MEM_WB_WD'(wb_c);
  assign mem_if.mem_fwd_bus     = FWD_WD'(fwd_c);

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level reference model.
module tb_mem_stage;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  mem_stage_if mem_if ();

  mem_stage dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: the instruction held in MEM and the word it loaded.
  logic        m_valid;
  logic        m_fresh;
  logic [73:0] m_bus;
  logic [31:0] m_word;

  function automatic logic [73:0] mk(input logic res, input logic [2:0] ld, input logic we,
                                     input logic [4:0] dest, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {res, ld, we, dest, alu, pc};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned b;
    int unsigned h;
    int          v;
    b = (word >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (word >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (ld)
      3'd1: begin v = int'(b); if (v > 127) v = v - 256; return 32'(v); end
      3'd2: return 32'(b);
      3'd3: begin v = int'(h); if (v > 32767) v = v - 65536; return 32'(v); end
      3'd4: return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, then compare outputs against the model.
  task automatic drive(input logic rst, input logic ev, input logic [73:0] bus,
                       input logic [31:0] rd, input logic wb);
    logic        exp_v;
    logic [31:0] exp_final;
    @(negedge clk);
    reset                   = rst;
    mem_if.exe_to_mem_valid = ev;
    mem_if.exe_to_mem_bus   = bus;
    mem_if.data_sram_rdata  = rd;
    mem_if.wb_allowin       = wb;
    #1;
    if (m_fresh) m_word = rd;
    exp_v = m_valid && !rst;
    chk("wb_valid", 70'(mem_if.mem_to_wb_valid), 70'(exp_v));
    chk("allowin", 70'(mem_if.mem_allowin), 70'(!exp_v || wb));
    if (exp_v) begin
      exp_final = m_bus[73] ? ref_load(m_bus[72:70], m_bus[63:32], m_word) : m_bus[63:32];
      chk("wb_bus", mem_if.mem_to_wb_bus, {m_bus[69], m_bus[68:64], exp_final, m_bus[31:0]});
      chk("fwd_bus", 70'(mem_if.mem_fwd_bus), 70'({m_bus[69], m_bus[68:64], exp_final}));
    end else begin
      chk("fwd_we", 70'(mem_if.mem_fwd_bus[37]), 70'(1'b0));
    end
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic tick();
    logic allow;
    @(posedge clk);
    allow = !m_valid || mem_if.wb_allowin;
    if (reset) begin
      m_valid = 1'b0;
      m_fresh = 1'b0;
    end else begin
      m_fresh = 1'b0;
      if (allow) begin
        m_valid = mem_if.exe_to_mem_valid;
        if (mem_if.exe_to_mem_valid) begin
          m_bus   = mem_if.exe_to_mem_bus;
          m_fresh = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [73:0] rbus;
    n_assert = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m_fresh  = 1'b0;
    m_bus    = '0;
    m_word   = '0;
    reset                   = 1'b1;
    mem_if.exe_to_mem_valid = 1'b0;
    mem_if.exe_to_mem_bus   = '0;
    mem_if.data_sram_rdata  = '0;
    mem_if.wb_allowin       = 1'b0;

    // Reset state.
    drive(1'b1, 1'b1, '0, 32'h0, 1'b0); tick();
    drive(1'b1, 1'b0, '0, 32'h0, 1'b0);
    chk("rst_valid", 70'(mem_if.mem_to_wb_valid), 70'(1'b0));
    chk("rst_allowin", 70'(mem_if.mem_allowin), 70'(1'b1));
    tick();

    // lb at 0x1003.
    drive(1'b0, 1'b1, mk(1'b1, 3'd1, 1'b1, 5'd7, 32'h1003, 32'h100), 32'h0, 1'b1); tick();
    drive(1'b0, 1'b0, '0, 32'h80FF1234, 1'b1);
    chk("lb_result", 70'(mem_if.mem_to_wb_bus[63:32]), 70'(32'hFFFFFF80));
    tick();

    // lhu then lh at 0x2002, back to back.
    drive(1'b0, 1'b1, mk(1'b1, 3'd4, 1'b1, 5'd8, 32'h2002, 32'h104), 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, mk(1'b1, 3'd3, 1'b1, 5'd9, 32'h2002, 32'h108), 32'hBEEF0001, 1'b1);
    chk("lhu_result", 70'(mem_if.mem_to_wb_bus[63:32]), 70'(32'h0000BEEF));
    tick();
    drive(1'b0, 1'b0, '0, 32'hBEEF0001, 1'b1);
    chk("lh_result", 70'(mem_if.mem_to_wb_bus[63:32]), 70'(32'hFFFFBEEF));
    tick();

    // lw stalled for three cycles keeps its first-cycle data.
    drive(1'b0, 1'b1, mk(1'b1, 3'd0, 1'b1, 5'd10, 32'h3000, 32'h10C), 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, mk(1'b0, 3'd0, 1'b1, 5'd11, 32'h77, 32'h110), 32'h11223344, 1'b0);
    chk("stall_allowin0", 70'(mem_if.mem_allowin), 70'(1'b0));
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, mk(1'b0, 3'd0, 1'b1, 5'd11, 32'h77, 32'h110), 32'hDEADBEEF, 1'b0);
      chk("stall_allowin", 70'(mem_if.mem_allowin), 70'(1'b0));
      tick();
    end
    drive(1'b0, 1'b0, '0, 32'hDEADBEEF, 1'b1);
    chk("stall_lw_result", 70'(mem_if.mem_to_wb_bus[63:32]), 70'(32'h11223344));
    tick();

    // add then lw with no bubble.
    drive(1'b0, 1'b1, mk(1'b0, 3'd0, 1'b1, 5'd3, 32'd5, 32'h200), 32'h0, 1'b1); tick();
    drive(1'b0, 1'b1, mk(1'b1, 3'd0, 1'b1, 5'd4, 32'h4000, 32'h204), 32'h0, 1'b1);
    chk("b2b_fwd", 70'(mem_if.mem_fwd_bus), 70'({1'b1, 5'd3, 32'd5}));
    tick();
    drive(1'b0, 1'b0, '0, 32'hCAFEF00D, 1'b1);
    chk("b2b_valid2", 70'(mem_if.mem_to_wb_valid), 70'(1'b1));
    tick();

    // Non-load without register write.
    drive(1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 5'd12, 32'h55, 32'h300), 32'h0, 1'b1); tick();
    drive(1'b0, 1'b0, '0, 32'h0, 1'b1);
    chk("nowe_fwd", 70'(mem_if.mem_fwd_bus[37]), 70'(1'b0));
    chk("nowe_wb", 70'(mem_if.mem_to_wb_bus[69]), 70'(1'b0));
    tick();

    // Reset during a stall discards the held instruction.
    drive(1'b0, 1'b1, mk(1'b0, 3'd0, 1'b1, 5'd13, 32'h66, 32'h400), 32'h0, 1'b1); tick();
    drive(1'b0, 1'b0, '0, 32'h0, 1'b0); tick();
    drive(1'b1, 1'b0, '0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b0, '0, 32'h0, 1'b0);
    chk("rst_stall_valid", 70'(mem_if.mem_to_wb_valid), 70'(1'b0));
    chk("rst_stall_fwd", 70'(mem_if.mem_fwd_bus[37]), 70'(1'b0));
    chk("rst_stall_allow", 70'(mem_if.mem_allowin), 70'(1'b1));
    tick();

    // Randomized traffic with occasional resets and stalls.
    for (int i = 0; i < 400; i++) begin
      rbus = mk(1'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
      drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), rbus, $urandom,
            1'($urandom_range(0, 2) != 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
